if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the P5 five-stage MIPS pipeline. Holds the program counter, drives the instruction-memory address, selects the next PC (sequential, branch, jump, register jump) and registers the fetched instruction into the IF/ID pipeline register. The branch target is formed from the ID-stage PC+4 plus the sign-extended, word-shifted immediate produced by the immediate extender (EXTOp = 2'b11). Stall requests from the hazard unit freeze the stage.

## Interface
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- stall  in  1  from hazard unit; freezes PC and IF/ID.
- br_taken  in  1  ID-stage branch comparator result.
- br_offset  in  32  extender output, sign-extended imm << 2.
- jump  in  1  ID instruction is j/jal.
- j_index  in  26  instr_index field of the ID instruction.
- jr  in  1  ID instruction is jr/jalr.
- jr_target  in  32  forwarded rs value.
- im_rdata  in  32  instruction memory read data for im_addr (combinational read).
- im_addr  out  32  current PC.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  32  registered PC of that instruction.
- if_id_pc4  out  32  registered PC+4.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- fetch_err  out  1  sticky: a misaligned jr target was taken.

## Operation
- Reset (reset = 0 at an edge): PC = PC_RESET; if_id_instr = NOP_WORD; if_id_pc = 0; if_id_pc4 = 0; if_id_valid = 0; fetch_err = 0. Reset overrides all other inputs, including mid-stall or mid-redirect.
- Redirect select, priority jr > jump > br_taken:
  - jr: target = {jr_target[31:2], 2'b00}; if jr_target[1:0] != 0, set fetch_err (sticky until reset).
  - jump: target = {if_id_pc4[31:28], j_index, 2'b00}.
  - br_taken: target = if_id_pc4 + br_offset, 32-bit wrap-around, no overflow detection.
  - none: next PC = PC + 4, wraps 32'hFFFF_FFFC -> 0.
- stall = 1: PC, all if_id_* and fetch_err hold. Redirect inputs are ignored (stall wins over a simultaneous redirect; the hazard unit re-presents the redirect once the stall clears).
- stall = 0, no redirect: PC <= PC + 4; IF/ID <= {im_rdata, PC, PC + 4, valid = 1}.
- stall = 0, redirect: PC <= target; IF/ID content per the configuration below.
- Redirect inputs are qualified by if_id_valid; a redirect asserted while if_id_valid = 0 is ignored.

## Timing
- im_addr = PC register output; no combinational path from any input to im_addr.
- Instruction fetched in cycle N appears on if_id_* in cycle N+1.
- Redirect sampled at edge N: im_addr = target from cycle N+1.
- First edge with reset = 1 after reset: IF/ID captures the word at PC_RESET; im_addr = PC_RESET + 4.
- fetch_err rises one cycle after the edge that samples the misaligned jr.

## Configuration
- IF_STAGE_DELAY_SLOT_EN defined: MIPS delay slot. On redirect, IF/ID still captures the instruction at the current PC (valid = 1); PC <= target.
- Undefined: no delay slot. On redirect, IF/ID loads NOP_WORD with if_id_valid = 0, if_id_pc = 0, if_id_pc4 = 0; the word at the current PC is discarded.

## Structure
- Shared package: PC_RESET, NOP_WORD, and the 2-bit next-PC select encoding (SEQ, BR, J, JR).
- Sub-module npc_sel: combinational next-PC mux plus the misalignment flag; the PC register, IF/ID register and fetch_err live in if_stage.

## Test plan
- Reset held for 3 cycles, then released with sequential fetch -> im_addr 0x3000, 0x3004, 0x3008; if_id_pc trails by one cycle; if_id_valid = 0 until the first capture.
- Branch taken in ID with if_id_pc4 = 0x3008 and br_offset = 0xFFFF_FFF8 -> im_addr = 0x3000 next cycle. With the delay-slot macro: IF/ID holds the word from 0x3008. Without it: bubble.
- jump with j_index = 0x000_0C10 and if_id_pc4 = 0x3010 -> im_addr = 0x0000_3040.
- stall = 1 for 2 cycles while br_taken = 1 -> PC and IF/ID unchanged. stall = 0 with br_taken = 1 -> redirect taken on that edge.
- jr with jr_target = 0x0000_3006 -> im_addr = 0x3004; fetch_err = 1 and stays 1 until reset = 0.
- jr and jump asserted together, with jr_target = 0x4000 -> im_addr = 0x4000 (jr has priority).

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the P5 MIPS instruction-fetch stage.
// Reset PC, bubble word, next-PC select encoding and the IF/ID bundle.
package if_stage_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_npc_sel.sv
// Combinational next-PC mux: jr > jump > branch > PC+4.
// Redirects only count when the ID-stage instruction is valid.
import if_stage_pkg::*;

module npc_sel (
    input  logic [31:0] pc,
    input  logic [31:0] if_id_pc4,
    input  logic        if_id_valid,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        jump,
    input  logic [25:0] j_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] npc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        misalign
);

    npc_sel_e sel;

    assign pc_plus4 = pc + 32'd4;

    // Prioritised select, then target mux
    always_comb begin
        sel = NPC_SEQ;
        if (if_id_valid) begin
            if (jr)            sel = NPC_JR;
            else if (jump)     sel = NPC_J;
            else if (br_taken) sel = NPC_BR;
        end
        unique case (sel)
            NPC_JR:  npc = word_align(jr_target);
            NPC_J:   npc = {if_id_pc4[31:28], j_index, 2'b00};
            NPC_BR:  npc = if_id_pc4 + br_offset;
            default: npc = pc_plus4;
        endcase
        redirect = (sel != NPC_SEQ);
        misalign = (sel == NPC_JR) && (jr_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/if_stage.sv
// P5 MIPS fetch stage: PC register, next-PC select, IF/ID register.
// IF_STAGE_DELAY_SLOT_EN keeps the fetched word on redirect (delay slot).
import if_stage_pkg::*;

module if_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        jump,
    input  logic [25:0] j_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic [31:0] im_rdata,
    output logic [31:0] im_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_err
);

    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    logic        fetch_err_q, fetch_err_d;

    logic [31:0] npc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        misalign;

    npc_sel u_npc_sel (
        .pc          (pc_q),
        .if_id_pc4   (if_id_q.pc4),
        .if_id_valid (if_id_q.valid),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .jump        (jump),
        .j_index     (j_index),
        .jr          (jr),
        .jr_target   (jr_target),
        .npc         (npc),
        .pc_plus4    (pc_plus4),
        .redirect    (redirect),
        .misalign    (misalign)
    );

    // Next-state: stall freezes everything, else advance or redirect
    always_comb begin
        pc_d        = pc_q;
        if_id_d     = if_id_q;
        fetch_err_d = fetch_err_q;
        if (!stall) begin
            pc_d        = npc;
            fetch_err_d = fetch_err_q | misalign;
            if (redirect) begin
`ifdef IF_STAGE_DELAY_SLOT_EN
                if_id_d = '{instr: im_rdata, pc: pc_q,
                            pc4: pc_plus4, valid: 1'b1};
`else
                if_id_d = '{instr: NOP_WORD, pc: '0,
                            pc4: '0, valid: 1'b0};
`endif
            end else begin
                if_id_d = '{instr: im_rdata, pc: pc_q,
                            pc4: pc_plus4, valid: 1'b1};
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q        <= PC_RESET;
            if_id_q     <= '{instr: NOP_WORD, pc: '0,
                             pc4: '0, valid: 1'b0};
            fetch_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            if_id_q     <= if_id_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign im_addr     = pc_q;
    assign if_id_instr = if_id_q.instr;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_valid = if_id_q.valid;
    assign fetch_err   = fetch_err_q;

endmodule
